// File: rtl/luna_core.sv
// rtl/luna_core.sv - multi-cycle Luna CPU core with req/ready instruction and data memory handshakes
// Optional retired-instruction counter port instret enabled by LUNA_CORE_PERF_EN.
module luna_core #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [PC_W-1:0]   pc_out,
`ifdef LUNA_CORE_PERF_EN
    output logic              halted,
    output logic [31:0]       instret
`else
    output logic              halted
`endif
);
    typedef enum logic [2:0] {FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, d_q, m_q, wdata_q, addr_q;
    logic [PC_W-1:0]   pc_q, npc_q;
    logic [15:0]       ir_q;

    logic              is_const, zx, zy, negf, ysel, dst_a, dst_d, dst_m;
    logic              j_lt, j_eq, j_gt, halt_bit;
    logic [1:0]        op;
    logic [DATA_W-1:0] x_val, y_val, raw, result, const_val;
    logic              res_neg, res_zero, take;
    logic [PC_W-1:0]   pc_inc, npc;
    logic              unused_ir;

    assign is_const  = ir_q[15];
    assign op        = ir_q[14:13];
    assign zx        = ir_q[12];
    assign zy        = ir_q[11];
    assign negf      = ir_q[10];
    assign ysel      = ir_q[9];
    assign dst_a     = ir_q[8];
    assign dst_d     = ir_q[7];
    assign dst_m     = ir_q[6];
    assign j_lt      = ir_q[5];
    assign j_eq      = ir_q[4];
    assign j_gt      = ir_q[3];
    assign halt_bit  = ir_q[2];
    assign unused_ir = ^ir_q[1:0];
    assign const_val = DATA_W'(ir_q[14:0]);

    always_comb begin
        x_val = zx ? '0 : d_q;
        y_val = zy ? '0 : (ysel ? m_q : a_q);
        case (op)
            2'b00:   raw = x_val + y_val;
            2'b01:   raw = x_val & y_val;
            2'b10:   raw = x_val | y_val;
            default: raw = x_val ^ y_val;
        endcase
        result   = negf ? -raw : raw;
        res_neg  = result[DATA_W-1];
        res_zero = (result == '0);
        take     = (j_lt & res_neg) | (j_eq & res_zero) | (j_gt & ~res_neg & ~res_zero);
        pc_inc   = pc_q + PC_W'(1);
        // Jump target is A as it stood before this instruction writes back.
        npc      = take ? a_q[PC_W-1:0] : pc_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (imem_ready) state_d = DECODE;
            DECODE: begin
                if (is_const)      state_d = FETCH;
                else if (halt_bit) state_d = HALT;
                else if (ysel)     state_d = MEM_RD;
                else               state_d = EXEC;
            end
            MEM_RD:  if (dmem_ready) state_d = EXEC;
            EXEC:    state_d = dst_m ? MEM_WR : FETCH;
            MEM_WR:  if (dmem_ready) state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        case (state_q)
            FETCH:   imem_req = 1'b1;
            MEM_RD:  dmem_req = 1'b1;
            MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    // A may be overwritten by the same instruction, so the write uses the saved copy.
    assign dmem_addr  = (state_q == MEM_WR) ? addr_q : a_q;
    assign dmem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            d_q     <= '0;
            m_q     <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
            npc_q   <= '0;
            ir_q    <= '0;
        end else begin
            case (state_q)
                FETCH:  if (imem_ready) ir_q <= imem_data;
                DECODE: if (is_const) begin
                    a_q  <= const_val;
                    pc_q <= pc_inc;
                end
                MEM_RD: if (dmem_ready) m_q <= dmem_rdata;
                EXEC: begin
                    if (dst_a) a_q <= result;
                    if (dst_d) d_q <= result;
                    wdata_q <= result;
                    addr_q  <= a_q;
                    if (dst_m) npc_q <= npc;
                    else       pc_q  <= npc;
                end
                MEM_WR: if (dmem_ready) pc_q <= npc_q;
                default: ;
            endcase
        end
    end

`ifdef LUNA_CORE_PERF_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = ((state_q == DECODE) && (is_const || halt_bit)) ||
                    ((state_q == EXEC) && !dst_m) ||
                    ((state_q == MEM_WR) && dmem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_luna_core.sv
// tb/tb_luna_core.sv - self-checking bench for luna_core against an instruction-level reference model
module tb_luna_core;
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic [7:0]  pc_out;
    logic        halted;
`ifdef LUNA_CORE_PERF_EN
    logic [31:0] instret;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    luna_core #(.DATA_W(16), .PC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc_out     (pc_out),
        .halted     (halted)
`ifdef LUNA_CORE_PERF_EN
        , .instret  (instret)
`endif
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [15:0] prog    [0:255];
    logic [15:0] dev_mem [0:255];
    logic [15:0] mmem    [0:255];
    logic [15:0] ma, md;
    logic [7:0]  mpc;
    bit          m_halted;
    int          exp_lat;
    int          m_retired;
    int          vectors = 0;
    int          miscompares = 0;

    // Architectural model: one call executes one whole instruction.
    task automatic model_step(input logic [15:0] ins);
        logic [15:0] x, y, r;
        logic        n, z, tk;
        acc_t        e;
        m_retired++;
        if (ins[15]) begin
            ma      = {1'b0, ins[14:0]};
            mpc     = mpc + 8'd1;
            exp_lat = 2;
        end else if (ins[2]) begin
            m_halted = 1'b1;
            exp_lat  = 2;
        end else begin
            x = ins[12] ? 16'h0 : md;
            y = ins[11] ? 16'h0 : (ins[9] ? mmem[ma[7:0]] : ma);
            case (ins[14:13])
                2'd0:    r = x + y;
                2'd1:    r = x & y;
                2'd2:    r = x | y;
                default: r = x ^ y;
            endcase
            if (ins[10]) r = 16'h0 - r;
            n  = r[15];
            z  = (r == 16'h0);
            tk = (ins[5] && n) || (ins[4] && z) || (ins[3] && !n && !z);
            if (ins[9]) begin
                e.we = 1'b0; e.addr = ma; e.data = 16'h0;
                exp_q.push_back(e);
            end
            if (ins[6]) begin
                e.we = 1'b1; e.addr = ma; e.data = r;
                exp_q.push_back(e);
                mmem[ma[7:0]] = r;
            end
            mpc = tk ? ma[7:0] : mpc + 8'd1;
            if (ins[8]) ma = r;
            if (ins[7]) md = r;
            exp_lat = 3 + int'(ins[9]) + int'(ins[6]);
        end
    endtask

    task automatic model_reset();
        ma = 16'h0; md = 16'h0; mpc = 8'h0; m_halted = 1'b0; m_retired = 0;
        exp_q.delete();
    endtask

    task automatic fill_mem();
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            dev_mem[i] = v;
            mmem[i]    = v;
            prog[i]    = 16'h0004;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_data = 16'h0; dmem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Plays instruction and data memory with random wait states and scores every access.
    task automatic run_prog(input int max_instr, input int max_wait, input int dwait_fixed);
        int          cyc = 0, start = 0, waits = 0, n_instr = 0, iwait = 0, dwait = 0;
        int          limit;
        bit          i_act = 0, d_act = 0, have_prev = 0, done = 0, exp_h;
        logic [7:0]  f_addr = 8'h0;
        logic        c_we = 1'b0;
        logic [15:0] c_addr = 16'h0, c_wdata = 16'h0;
        acc_t        e;
        limit = 40 * max_instr + 100;
        while (!done && cyc < limit) begin
            @(negedge clk);
            exp_h = m_halted && (cyc >= start + waits + 2);
            vectors++;
            if (halted !== exp_h) begin
                miscompares++;
                $display("FAIL halted: got %b expected %b at cycle %0d", halted, exp_h, cyc);
            end
            if (m_halted) begin
                vectors++;
                if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL halt_quiet: imem_req %b dmem_req %b, both required 0", imem_req, dmem_req);
                end
                if (cyc >= start + waits + 10) done = 1;
            end
            imem_ready = 1'b0;
            imem_data  = 16'($urandom);
            if (imem_req && !m_halted) begin
                if (!i_act) begin
                    if (have_prev) begin
                        vectors++;
                        if (cyc - start != exp_lat + waits) begin
                            miscompares++;
                            $display("FAIL latency: got %0d cycles expected %0d", cyc - start, exp_lat + waits);
                        end
                    end
                    vectors++;
                    if (imem_addr !== mpc || pc_out !== mpc) begin
                        miscompares++;
                        $display("FAIL fetch_addr: imem_addr %h pc_out %h expected %h", imem_addr, pc_out, mpc);
                    end
                    if (n_instr == max_instr) done = 1;
                    i_act = 1; f_addr = imem_addr; start = cyc; waits = 0;
                    iwait = $urandom_range(0, max_wait);
                end else begin
                    vectors++;
                    if (imem_addr !== f_addr) begin
                        miscompares++;
                        $display("FAIL imem_hold: addr %h expected %h", imem_addr, f_addr);
                    end
                end
                if (!done) begin
                    if (iwait == 0) begin
                        imem_ready = 1'b1;
                        imem_data  = prog[imem_addr];
                        i_act = 0; have_prev = 1; n_instr++;
                        model_step(prog[mpc]);
                    end else begin
                        iwait--; waits++;
                    end
                end
            end else if (!imem_req) begin
                imem_ready = 1'($urandom_range(0, 1));
            end
            dmem_ready = 1'b0;
            dmem_rdata = 16'($urandom);
            if (dmem_req && !m_halted) begin
                if (!d_act) begin
                    d_act = 1; c_we = dmem_we; c_addr = dmem_addr; c_wdata = dmem_wdata;
                    dwait = (dwait_fixed >= 0) ? dwait_fixed : $urandom_range(0, max_wait);
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL dmem_unexpected: we %b addr %h, no access required", c_we, c_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (c_we !== e.we || c_addr !== e.addr || (e.we && c_wdata !== e.data)) begin
                            miscompares++;
                            $display("FAIL dmem_access: we %b addr %h wdata %h expected we %b addr %h wdata %h",
                                     c_we, c_addr, c_wdata, e.we, e.addr, e.data);
                        end
                    end
                end else begin
                    vectors++;
                    if (dmem_we !== c_we || dmem_addr !== c_addr || (c_we && dmem_wdata !== c_wdata)) begin
                        miscompares++;
                        $display("FAIL dmem_hold: we %b addr %h wdata %h expected we %b addr %h wdata %h",
                                 dmem_we, dmem_addr, dmem_wdata, c_we, c_addr, c_wdata);
                    end
                end
                if (dwait == 0) begin
                    dmem_ready = 1'b1;
                    if (c_we) dev_mem[c_addr[7:0]] = c_wdata;
                    else      dmem_rdata = dev_mem[c_addr[7:0]];
                    d_act = 0;
                end else begin
                    dwait--; waits++;
                end
            end else if (!dmem_req) begin
                dmem_ready = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: %0d cycles, %0d of %0d instructions issued", cyc, n_instr, max_instr);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL dmem_missing: %0d accesses never made, expected 0", exp_q.size());
        end
`ifdef LUNA_CORE_PERF_EN
        vectors++;
        if (instret !== 32'(m_retired)) begin
            miscompares++;
            $display("FAIL instret: got %0d expected %0d", instret, m_retired);
        end
`endif
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        fill_mem();
        do_reset();
        vectors++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || halted !== 1'b0 ||
            pc_out !== 8'h0 || imem_addr !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: dmem_req %b we %b halted %b pc %h addr %h expected 0 0 0 00 00",
                     dmem_req, dmem_we, halted, pc_out, imem_addr);
        end
`ifdef LUNA_CORE_PERF_EN
        vectors++;
        if (instret !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
`endif
    endtask

    task automatic test_constant();
        fill_mem();
        prog[0] = 16'h8005; prog[1] = 16'h1080; prog[2] = 16'h8020;
        prog[3] = 16'h0840; prog[4] = 16'h0004;
        do_reset();
        run_prog(10, 0, -1);
        vectors++;
        if (dev_mem[8'h20] !== 16'h0005) begin
            miscompares++;
            $display("FAIL const_store: mem[20] %h expected 0005", dev_mem[8'h20]);
        end
        vectors++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc_out !== 8'h04) begin
            miscompares++;
            $display("FAIL halt_state: halted %b imem_req %b pc %h expected 1 0 04", halted, imem_req, pc_out);
        end
    endtask

    task automatic test_mem_read();
        fill_mem();
        prog[0] = 16'h8007; prog[1] = 16'h1080; prog[2] = 16'h8010; prog[3] = 16'h0280;
        prog[4] = 16'h8030; prog[5] = 16'h0840; prog[6] = 16'h0004;
        dev_mem[8'h10] = 16'h1234;
        mmem[8'h10]    = 16'h1234;
        do_reset();
        run_prog(10, 0, 3);
        vectors++;
        if (dev_mem[8'h30] !== 16'h123B) begin
            miscompares++;
            $display("FAIL mem_read_sum: mem[30] %h expected 123b", dev_mem[8'h30]);
        end
    endtask

    task automatic test_jump();
        fill_mem();
        prog[0] = 16'h8003; prog[1] = 16'h1080; prog[2] = 16'h8040; prog[3] = 16'h3010;
        prog[8'h40] = 16'h3020; prog[8'h41] = 16'h0004;
        do_reset();
        run_prog(10, 2, -1);
        vectors++;
        if (pc_out !== 8'h41) begin
            miscompares++;
            $display("FAIL jump_pc: pc %h expected 41", pc_out);
        end
    endtask

    task automatic test_pc_wrap();
        fill_mem();
        prog[0] = 16'h80FF; prog[1] = 16'h1838; prog[8'hFF] = 16'h8007;
        do_reset();
        run_prog(3, 1, -1);
        vectors++;
        if (pc_out !== 8'h00) begin
            miscompares++;
            $display("FAIL pc_wrap: pc %h expected 00", pc_out);
        end
    endtask

    task automatic test_reset_pending();
        int  seen = 0;
        fill_mem();
        prog[0] = 16'h8010; prog[1] = 16'h0280;
        do_reset();
        for (int i = 0; i < 30 && seen < 3; i++) begin
            @(negedge clk);
            imem_ready = imem_req;
            imem_data  = prog[imem_addr];
            dmem_ready = 1'b0;
            if (dmem_req) seen++;
        end
        vectors++;
        if (dmem_req !== 1'b1 || dmem_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL pending_req: dmem_req %b addr %h expected 1 0010", dmem_req, dmem_addr);
        end
        rst_n = 1'b0;
        dmem_ready = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || pc_out !== 8'h00 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pending: dmem_req %b we %b pc %h halted %b expected 0 0 00 0",
                     dmem_req, dmem_we, pc_out, halted);
        end
        rst_n = 1'b1;
        dmem_ready = 1'b0;
        model_reset();
        run_prog(10, 1, -1);
    endtask

    task automatic test_random(input int rounds, input int max_wait);
        logic [31:0] r;
        logic [15:0] ins;
        for (int k = 0; k < rounds; k++) begin
            fill_mem();
            for (int i = 0; i < 256; i++) begin
                r = $urandom;
                if (r[31:30] == 2'b00) begin
                    ins = {1'b1, r[14:0]};
                end else begin
                    ins = {1'b0, r[14:0]};
                    if ($urandom_range(0, 39) != 0) ins[2] = 1'b0;
                end
                prog[i] = ins;
            end
            do_reset();
            run_prog(150, max_wait, -1);
        end
    endtask

    task automatic test_back_to_back();
        test_random(1, 0);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_data = 16'h0;
        dmem_ready = 1'b0; dmem_rdata = 16'h0;
        model_reset();
        test_reset();
        test_constant();
        test_mem_read();
        test_jump();
        test_pc_wrap();
        test_reset_pending();
        test_back_to_back();
        test_random(3, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
